// File: rtl/tm1638_hex_writer.sv
// ----------------------------------------------------------------------------
// tm1638_hex_writer
//   Bus master placed directly upstream of the TM1638 register bank. A start
//   pulse captures a 32-bit value and converts it into eight hex
//   seven-segment digit bytes. It writes those bytes, then an LED byte, into
//   the bank over a simple wr/addr/dout bus. It ends with one read of the
//   buttons register, whose result is held on `buttons`.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   start     1-cycle request, honoured only when idle
//   value     hex value to display, [31:28] is the leftmost digit
//   dp_mask   decimal points, bit7 = leftmost digit .. bit0 = rightmost
//   leds_in   LED byte written at offset 8
//   blank_lz  1 = suppress leading zero digits (rightmost digit always shown)
//   bus_addr  register-bank address {CFG_ADDR, offset}
//   bus_dout  write data to the bank
//   bus_wr    write strobe, one cycle per register
//   bus_rd    read strobe
//   bus_din   read data from the bank (combinational on its side)
//   busy      sequence in progress
//   done      1-cycle completion pulse
//   buttons   last button byte read
// ----------------------------------------------------------------------------
module tm1638_hex_writer #(
   parameter logic [11:0] CFG_ADDR = 12'hff0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  leds_in,
   input  logic        blank_lz,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_wr,
   output logic        bus_rd,
   input  logic [7:0]  bus_din,
   output logic        busy,
   output logic        done,
   output logic [7:0]  buttons
);

   typedef enum logic [2:0] {S_IDLE, S_WDIG, S_WLED, S_RBTN, S_DONE} state_t;

   // The state names the bus cycle currently presented on the outputs.
   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] addr_d;
   logic [7:0]  dout_d, btn_d;
   logic        wr_d, rd_d, busy_d, done_d;
   logic        load;

   logic [31:0] val_q;
   logic [7:0]  dp_q, leds_q;
   logic        blz_q;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   // Digit i (0 = leftmost) shows nibble value[31-4i -: 4]; for a 3-bit
   // index, 7-i equals ~i. The digit is a leading zero when every nibble
   // from the left up to and including it is zero, i.e. when the value
   // shifted right by 4*(7-i) is zero.
   function automatic logic [7:0] digit_byte(input logic [31:0] v,
                                             input logic [7:0]  dp,
                                             input logic        blz,
                                             input logic [2:0]  i);
      logic [31:0] upper;
      logic        blank;
      upper = v >> {~i, 2'b00};
      blank = blz && (i != 3'd7) && (upper == 32'd0);
      digit_byte = {dp[~i], blank ? 7'h00 : seg7(upper[3:0])};
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = '0;
      dout_d  = '0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      busy_d  = busy;
      done_d  = 1'b0;
      btn_d   = buttons;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // The first digit is driven from the live inputs because the
               // latched copies are only loaded at this same edge.
               load    = 1'b1;
               state_d = S_WDIG;
               idx_d   = 3'd0;
               busy_d  = 1'b1;
               wr_d    = 1'b1;
               addr_d  = {CFG_ADDR, 4'h0};
               dout_d  = digit_byte(value, dp_mask, blank_lz, 3'd0);
            end
         end
         S_WDIG: begin
            wr_d = 1'b1;
            if (idx_q == 3'd7) begin
               state_d = S_WLED;
               addr_d  = {CFG_ADDR, 4'h8};
               dout_d  = leds_q;
            end else begin
               idx_d  = idx_q + 3'd1;
               addr_d = {CFG_ADDR, 1'b0, idx_d};
               dout_d = digit_byte(val_q, dp_q, blz_q, idx_d);
            end
         end
         S_WLED: begin
            state_d = S_RBTN;
            rd_d    = 1'b1;
            addr_d  = {CFG_ADDR, 4'h9};
         end
         S_RBTN: begin
            btn_d   = bus_din;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         bus_addr <= '0;
         bus_dout <= '0;
         bus_wr   <= 1'b0;
         bus_rd   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         buttons  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         bus_addr <= addr_d;
         bus_dout <= dout_d;
         bus_wr   <= wr_d;
         bus_rd   <= rd_d;
         busy     <= busy_d;
         done     <= done_d;
         buttons  <= btn_d;
      end
   end

   // Request capture; inputs are ignored for the rest of the sequence.
   always_ff @(posedge clk) begin
      if (load) begin
         val_q  <= value;
         dp_q   <= dp_mask;
         leds_q <= leds_in;
         blz_q  <= blank_lz;
      end
   end

endmodule
